// File: rtl/counter_opc_mod_pkg.sv
// counter_opc_mod_pkg
// Shared definitions for the opcode-driven counter:
//   - opcode width and encodings
//   - add/subtract direction type
package counter_opc_mod_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OPC_HOLD   = 3'd0,
    OPC_INC    = 3'd1,
    OPC_DEC    = 3'd2,
    OPC_CLR    = 3'd3,
    OPC_LOAD   = 3'd4,
    OPC_PRESET = 3'd5,
    OPC_RSV6   = 3'd6,
    OPC_RSV7   = 3'd7
  } opc_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_opc_mod_if.sv
// counter_opc_mod_if
// Control/status bundle of the opcode-driven counter.
//   en      operation enable (0 = hold, no flag pulses)
//   opc     operation code
//   d       parallel load value
//   step    increment/decrement amount
//   counter registered count value
//   z, top  count == 0 / count == MAX_VAL
//   ovf     1-cycle pulse, increment crossed MAX_VAL
//   unf     1-cycle pulse, decrement crossed 0
//   err     1-cycle pulse, illegal load value or step
// master: the controlling FSM. slave: the counter.
interface counter_opc_mod_if #(
  parameter int SIZE = 8
);
  import counter_opc_mod_pkg::*;

  logic             en;
  logic [OPC_W-1:0] opc;
  logic [SIZE-1:0]  d;
  logic [SIZE-1:0]  step;
  logic [SIZE-1:0]  counter;
  logic             z;
  logic             top;
  logic             ovf;
  logic             unf;
  logic             err;

  modport master (
    output en, opc, d, step,
    input  counter, z, top, ovf, unf, err
  );

  modport slave (
    input  en, opc, d, step,
    output counter, z, top, ovf, unf, err
  );

endinterface

// File: rtl/counter_opc_mod_addsub.sv
// mod_addsub
// Combinational modulo-M add/subtract, M = MAX_VAL+1.
//   value     current count (always within 0..MAX_VAL)
//   step      amount to add or subtract
//   dir       DIR_UP adds, DIR_DOWN subtracts
//   next      resulting count (equals value when step is 0 or illegal)
//   crossed   the operation passed MAX_VAL (up) or 0 (down)
//   step_err  step > MAX_VAL
// Arithmetic runs at SIZE+1 bits so carry and borrow are visible.
module mod_addsub
  import counter_opc_mod_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int MAX_VAL  = 2**SIZE-1,
  parameter int SATURATE = 0
) (
  input  logic [SIZE-1:0] value,
  input  logic [SIZE-1:0] step,
  input  dir_e            dir,
  output logic [SIZE-1:0] next,
  output logic            crossed,
  output logic            step_err
);

  localparam logic [SIZE:0] MAX_EXT = (SIZE+1)'(MAX_VAL);
  // M itself fits in SIZE+1 bits even when MAX_VAL = 2**SIZE-1.
  localparam logic [SIZE:0] MOD_EXT = MAX_EXT + 1'b1;

  logic [SIZE:0] value_ext;
  logic [SIZE:0] step_ext;
  logic [SIZE:0] sum;
  logic [SIZE:0] sum_wrap;
  logic [SIZE:0] diff;
  logic [SIZE:0] diff_wrap;
  logic          step_zero;

  assign value_ext = {1'b0, value};
  assign step_ext  = {1'b0, step};
  assign sum       = value_ext + step_ext;
  assign sum_wrap  = sum - MOD_EXT;
  assign diff      = value_ext - step_ext;
  // Adding M before subtracting keeps the intermediate non-negative.
  assign diff_wrap = value_ext + MOD_EXT - step_ext;
  assign step_zero = (step == '0);
  assign step_err  = (step_ext > MAX_EXT);

  always_comb begin
    next    = value;
    crossed = 1'b0;
    if (!step_zero && !step_err) begin
      if (dir == DIR_UP) begin
        if (sum > MAX_EXT) begin
          crossed = 1'b1;
          next    = (SATURATE != 0) ? MAX_EXT[SIZE-1:0] : sum_wrap[SIZE-1:0];
        end else begin
          next = sum[SIZE-1:0];
        end
      end else begin
        if (step_ext > value_ext) begin
          crossed = 1'b1;
          next    = (SATURATE != 0) ? '0 : diff_wrap[SIZE-1:0];
        end else begin
          next = diff[SIZE-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/counter_opc_mod.sv
// counter_opc_mod
// Up/down counter with programmable modulus, variable step, parallel
// load and wrap/saturate overflow handling.
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-low
//   bus    counter_opc_mod_if slave port (controls in, count/flags out)
// Parameters: SIZE (width, >=2), MAX_VAL (1..2**SIZE-1),
// SATURATE (0 = wrap modulo MAX_VAL+1, 1 = clamp at 0 / MAX_VAL).
// count, ovf, unf and err are registered; z and top decode the count only.
module counter_opc_mod
  import counter_opc_mod_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int MAX_VAL  = 2**SIZE-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_opc_mod_if.slave bus
);

  localparam logic [SIZE:0] MAX_EXT = (SIZE+1)'(MAX_VAL);

  logic [SIZE-1:0] cnt_q;
  logic            ovf_q;
  logic            unf_q;
  logic            err_q;

  opc_e            opc;
  dir_e            as_dir;
  logic [SIZE-1:0] as_next;
  logic            as_crossed;
  logic            as_step_err;
  logic            load_err;

  assign opc      = opc_e'(bus.opc);
  assign as_dir   = (opc == OPC_DEC) ? DIR_DOWN : DIR_UP;
  assign load_err = ({1'b0, bus.d} > MAX_EXT);

  mod_addsub #(
    .SIZE     (SIZE),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_addsub (
    .value    (cnt_q),
    .step     (bus.step),
    .dir      (as_dir),
    .next     (as_next),
    .crossed  (as_crossed),
    .step_err (as_step_err)
  );

  // Flags default low every edge, so each is a single-cycle pulse and
  // at most one of them can be set by the one operation decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.en) begin
        case (opc)
          OPC_INC, OPC_DEC: begin
            if (as_step_err) begin
              err_q <= 1'b1;
            end else begin
              cnt_q <= as_next;
              if (as_dir == DIR_UP) ovf_q <= as_crossed;
              else                  unf_q <= as_crossed;
            end
          end
          OPC_CLR:    cnt_q <= '0;
          OPC_LOAD: begin
            if (load_err) err_q <= 1'b1;
            else          cnt_q <= bus.d;
          end
          OPC_PRESET: cnt_q <= MAX_EXT[SIZE-1:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.counter = cnt_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.err     = err_q;
  assign bus.z       = (cnt_q == '0);
  assign bus.top     = ({1'b0, cnt_q} == MAX_EXT);

endmodule

// File: tb/tb_counter_opc_mod.sv
// tb_counter_opc_mod
// Three SIZE=4 counters: A (MAX_VAL=9, wrap), S (MAX_VAL=9, saturate),
// F (MAX_VAL=15, wrap). Status is packed as {count, z, top, ovf, unf, err}.
module tb_counter_opc_mod;
  import counter_opc_mod_pkg::*;

  localparam int DA = 0;
  localparam int DS = 1;
  localparam int DF = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  int         sel;
  logic [2:0] opc;
  logic [3:0] d;
  logic [3:0] step;

  int vectors;
  int miscompares;

  counter_opc_mod_if #(.SIZE(4)) if_a ();
  counter_opc_mod_if #(.SIZE(4)) if_s ();
  counter_opc_mod_if #(.SIZE(4)) if_f ();

  assign if_a.en   = en && (sel == DA);
  assign if_s.en   = en && (sel == DS);
  assign if_f.en   = en && (sel == DF);
  assign if_a.opc  = opc;
  assign if_s.opc  = opc;
  assign if_f.opc  = opc;
  assign if_a.d    = d;
  assign if_s.d    = d;
  assign if_f.d    = d;
  assign if_a.step = step;
  assign if_s.step = step;
  assign if_f.step = step;

  counter_opc_mod #(.SIZE(4), .MAX_VAL(9),  .SATURATE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  counter_opc_mod #(.SIZE(4), .MAX_VAL(9),  .SATURATE(1)) u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
  counter_opc_mod #(.SIZE(4), .MAX_VAL(15), .SATURATE(0)) u_f (.clk(clk), .rst_n(rst_n), .bus(if_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] st(input int s);
    case (s)
      DA:      return {if_a.counter, if_a.z, if_a.top, if_a.ovf, if_a.unf, if_a.err};
      DS:      return {if_s.counter, if_s.z, if_s.top, if_s.ovf, if_s.unf, if_s.err};
      default: return {if_f.counter, if_f.z, if_f.top, if_f.ovf, if_f.unf, if_f.err};
    endcase
  endfunction

  task automatic chk(input string tag, input int s, input logic [8:0] exp);
    logic [8:0] obs;
    obs = st(s);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed cnt=%0d flags(z,top,ovf,unf,err)=%b expected cnt=%0d flags=%b",
             tag, obs[8:5], obs[4:0], exp[8:5], exp[4:0]);
    end
  endtask

  task automatic op(input int s, input logic e, input logic [2:0] o,
                    input logic [3:0] dv, input logic [3:0] sv);
    @(negedge clk);
    sel  = s;
    en   = e;
    opc  = o;
    d    = dv;
    step = sv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] m;
    logic [3:0] rs;
    logic [3:0] rd;
    logic [2:0] ro;
    logic       eo;
    logic       eu;
    int         sum;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = DA;
    opc   = 3'd0;
    d     = 4'd0;
    step  = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_a", DA, {4'd0, 5'b10000});
    chk("reset_s", DS, {4'd0, 5'b10000});
    chk("reset_f", DF, {4'd0, 5'b10000});
    rst_n = 1'b1;

    // asynchronous reset mid-cycle, with an ovf pulse pending on S
    op(DA, 1'b1, OPC_INC, 4'd0, 4'd7);
    chk("inc_to_7", DA, {4'd7, 5'b00000});
    op(DS, 1'b1, OPC_PRESET, 4'd0, 4'd0);
    op(DS, 1'b1, OPC_INC, 4'd0, 4'd1);
    chk("sat_top_ovf", DS, {4'd9, 5'b01100});
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_a", DA, {4'd0, 5'b10000});
    chk("async_rst_s", DS, {4'd0, 5'b10000});
    #2 rst_n = 1'b1;

    // wrap overflow / underflow, single-cycle pulses
    op(DA, 1'b1, OPC_LOAD, 4'd8, 4'd0);
    chk("load_8", DA, {4'd8, 5'b00000});
    op(DA, 1'b1, OPC_INC, 4'd0, 4'd3);
    chk("wrap_inc", DA, {4'd1, 5'b00100});
    op(DA, 1'b1, OPC_HOLD, 4'd0, 4'd3);
    chk("ovf_one_cycle", DA, {4'd1, 5'b00000});
    op(DA, 1'b1, OPC_DEC, 4'd0, 4'd3);
    chk("wrap_dec", DA, {4'd8, 5'b00010});
    op(DA, 1'b1, OPC_HOLD, 4'd0, 4'd0);
    chk("unf_one_cycle", DA, {4'd8, 5'b00000});

    // saturate mode
    op(DS, 1'b1, OPC_LOAD, 4'd8, 4'd0);
    op(DS, 1'b1, OPC_INC, 4'd0, 4'd3);
    chk("sat_inc1", DS, {4'd9, 5'b01100});
    op(DS, 1'b1, OPC_INC, 4'd0, 4'd3);
    chk("sat_inc2", DS, {4'd9, 5'b01100});
    op(DS, 1'b1, OPC_DEC, 4'd0, 4'd9);
    chk("sat_dec1", DS, {4'd0, 5'b10000});
    op(DS, 1'b1, OPC_DEC, 4'd0, 4'd9);
    chk("sat_dec2", DS, {4'd0, 5'b10010});
    op(DS, 1'b1, OPC_DEC, 4'd0, 4'd1);
    chk("sat_dec3", DS, {4'd0, 5'b10010});

    // illegal load / step
    op(DA, 1'b1, OPC_LOAD, 4'd12, 4'd0);
    chk("load_illegal", DA, {4'd8, 5'b00001});
    op(DA, 1'b1, OPC_LOAD, 4'd5, 4'd0);
    chk("load_5", DA, {4'd5, 5'b00000});
    op(DA, 1'b1, OPC_INC, 4'd0, 4'd10);
    chk("inc_step_illegal", DA, {4'd5, 5'b00001});
    op(DA, 1'b1, OPC_DEC, 4'd0, 4'd15);
    chk("dec_step_illegal", DA, {4'd5, 5'b00001});
    op(DA, 1'b1, OPC_INC, 4'd0, 4'd0);
    chk("inc_step0", DA, {4'd5, 5'b00000});
    op(DA, 1'b1, OPC_DEC, 4'd0, 4'd0);
    chk("dec_step0", DA, {4'd5, 5'b00000});

    // enable low, preset, clear, reserved opcodes
    for (int i = 0; i < 5; i++) begin
      op(DA, 1'b0, OPC_INC, 4'd0, 4'd1);
      chk("en_low_hold", DA, {4'd5, 5'b00000});
    end
    op(DA, 1'b1, OPC_PRESET, 4'd0, 4'd0);
    chk("preset", DA, {4'd9, 5'b01000});
    op(DA, 1'b1, OPC_CLR, 4'd0, 4'd0);
    chk("clr", DA, {4'd0, 5'b10000});
    op(DA, 1'b1, OPC_LOAD, 4'd3, 4'd0);
    op(DA, 1'b1, 3'd6, 4'd7, 4'd1);
    chk("opc6_hold", DA, {4'd3, 5'b00000});
    op(DA, 1'b1, 3'd7, 4'd7, 4'd1);
    chk("opc7_hold", DA, {4'd3, 5'b00000});

    // full-width modulus: plain 4-bit rollover
    op(DF, 1'b1, OPC_PRESET, 4'd0, 4'd0);
    chk("f_preset", DF, {4'd15, 5'b01000});
    op(DF, 1'b1, OPC_INC, 4'd0, 4'd1);
    chk("f_inc_roll", DF, {4'd0, 5'b10100});
    op(DF, 1'b1, OPC_DEC, 4'd0, 4'd1);
    chk("f_dec_roll", DF, {4'd15, 5'b01010});
    op(DF, 1'b1, OPC_INC, 4'd0, 4'd15);
    chk("f_inc_15", DF, {4'd14, 5'b00100});
    op(DF, 1'b1, OPC_LOAD, 4'd15, 4'd0);
    chk("f_load_15", DF, {4'd15, 5'b01000});

    // randomised INC/DEC/LOAD against a modulo-16 reference
    m = 4'd15;
    for (int i = 0; i < 40; i++) begin
      rs = 4'($urandom_range(0, 15));
      if (i % 8 == 0) rs = 4'd0;
      rd = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       ro = OPC_INC;
        1:       ro = OPC_DEC;
        default: ro = OPC_LOAD;
      endcase
      eo = 1'b0;
      eu = 1'b0;
      if (ro == OPC_LOAD) begin
        m = rd;
      end else if (ro == OPC_INC) begin
        sum = int'(m) + int'(rs);
        eo  = (sum > 15);
        m   = 4'(sum % 16);
      end else begin
        sum = int'(m) - int'(rs);
        eu  = (sum < 0);
        m   = 4'((sum + 16) % 16);
      end
      op(DF, 1'b1, ro, rd, rs);
      chk("f_rand", DF, {m, (m == 4'd0), (m == 4'd15), eo, eu, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_opc_mod.md
Name: counter_opc_mod

Overview:
Parametrised up/down counter with a programmable modulus, variable step, parallel load, and wrap or saturate overflow mode. It is the next-generation opcode-driven counter for the encoder and state-machine datapaths. It adds terminal-count, overflow, underflow and error flags so that downstream FSMs need no extra compare logic.

Parameters:
SIZE, 8, counter width in bits (>=2)
MAX_VAL, 2**SIZE-1, upper bound of count range; legal range 1..2**SIZE-1; modulus M = MAX_VAL+1
SATURATE, 0, 0 = wrap modulo M; 1 = clamp at 0 / MAX_VAL

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous reset, active-low
EN  in  1  operation enable; 0 = hold, no flag pulses
OPC  in  3  operation code (see Behaviour)
D  in  SIZE  parallel load value
STEP  in  SIZE  increment/decrement amount
COUNTER  out  SIZE  registered count value
Z  out  1  COUNTER == 0 (combinational from COUNTER)
TOP  out  1  COUNTER == MAX_VAL (combinational from COUNTER)
OVF  out  1  registered 1-cycle pulse: increment crossed MAX_VAL
UNF  out  1  registered 1-cycle pulse: decrement crossed 0
ERR  out  1  registered 1-cycle pulse: illegal load or step, operation ignored

Behaviour:
- Reset (RESET_N=0, asynchronous, immediate): COUNTER=0, OVF=UNF=ERR=0, so Z=1 and TOP=0.
- Deassertion of RESET_N is synchronous to CLK by the system; the first edge after release executes normally.
- All updates occur on the rising CLK edge. COUNTER and the pulse flags are valid one cycle after the edge that samples EN/OPC/D/STEP.
- OPC decoding (evaluated only when EN=1):
  - 0 HOLD: no change.
  - 1 INC: COUNTER += STEP.
  - 2 DEC: COUNTER -= STEP.
  - 3 CLR: COUNTER = 0.
  - 4 LOAD: COUNTER = D.
  - 5 PRESET: COUNTER = MAX_VAL.
  - 6, 7 RESERVED: behave as HOLD, no flags.
- Arithmetic is computed at SIZE+1 bits to capture carry and borrow.
- INC, wrap mode: if COUNTER+STEP > MAX_VAL, COUNTER = COUNTER+STEP-M and OVF=1; otherwise COUNTER = COUNTER+STEP.
- DEC, wrap mode: if STEP > COUNTER, COUNTER = COUNTER-STEP+M and UNF=1; otherwise COUNTER = COUNTER-STEP.
- Saturate mode: an overflowing INC gives COUNTER=MAX_VAL with OVF=1; an underflowing DEC gives COUNTER=0 with UNF=1.
  - INC while already at MAX_VAL with STEP>0 pulses OVF every cycle it is applied.
  - DEC while already at 0 with STEP>0 pulses UNF every cycle it is applied.
- STEP=0 on INC/DEC: hold, no flags.
- STEP > MAX_VAL on INC/DEC: hold, ERR=1, no OVF/UNF.
- LOAD with D > MAX_VAL: hold, ERR=1. LOAD with a legal D sets no flags.
- CLR and PRESET never raise flags.
- At most one of OVF/UNF/ERR is high in any cycle. All three are 0 in any cycle following an edge with EN=0.
- Boundary case MAX_VAL = 2**SIZE-1: the modulus equals the natural width, and wrap must equal plain SIZE-bit rollover.
- Reset mid-operation: a pending flag pulse is cleared immediately, and no partial update is retained.
- No combinational path from inputs to COUNTER/OVF/UNF/ERR.
- Z and TOP depend only on COUNTER.

Decomposition:
- Shared header counter_opc_defs.vh holds:
  - OPC encodings OPC_HOLD=3'd0, OPC_INC=3'd1, OPC_DEC=3'd2, OPC_CLR=3'd3, OPC_LOAD=3'd4, OPC_PRESET=3'd5.
  - The OPC width constant.
- One sub-module, mod_addsub (parameters SIZE, MAX_VAL, SATURATE), is purely combinational.
  - Inputs: current value, STEP, direction.
  - Outputs: next value, crossed flag, step_err flag.
- The top level holds the OPC decode, the register, and the flag registers.

Test Plan:
1. SIZE=4, MAX_VAL=9, wrap; count to 7, then drop RESET_N between clock edges -> COUNTER=0, Z=1 immediately, OVF/UNF/ERR=0, before the next edge.
2. Wrap mode, COUNTER=8, STEP=3, OPC=INC -> COUNTER=1, OVF=1 for exactly one cycle. Then OPC=DEC with STEP=3 -> COUNTER=8, UNF=1.
3. SATURATE=1, COUNTER=8, STEP=3, INC twice -> COUNTER=9, TOP=1, OVF=1 both cycles. Then DEC with STEP=9 twice -> COUNTER=0, Z=1 after the first, then UNF=1 on the second.
4. LOAD D=12 with MAX_VAL=9 -> COUNTER unchanged, ERR=1. LOAD D=5 -> COUNTER=5, ERR=0. INC with STEP=10 -> hold, ERR=1.
5. EN=0 with OPC=INC, STEP=1 for 5 cycles -> COUNTER constant, no pulses. EN=1, PRESET -> COUNTER=9, TOP=1. CLR -> COUNTER=0, Z=1. OPC=6 -> hold.
6. SIZE=4, MAX_VAL=15, wrap; COUNTER=15, INC STEP=1 -> COUNTER=0, OVF=1. DEC STEP=1 -> COUNTER=15, UNF=1. Run a randomised INC/DEC/LOAD sequence against a reference model, including STEP=0 cases.
